// File: rtl/uart_rx_fifo_if.sv
// Stream bundle between the UART receiver, the receive FIFO and its consumer.
// s_axis_* carries received characters into the FIFO, m_axis_* carries them out.
// Handshake: a beat moves on a rising clk edge when tvalid and tready are both
// high; tdata/tuser must hold steady while tvalid=1 and tready=0. The s_axis side
// never back-pressures (s_axis_tready is constant 1).
interface uart_rx_fifo_if #(
    parameter int Databits = 8
);
    logic [Databits-1:0] s_axis_tdata;
    logic                s_axis_tvalid;
    logic                s_axis_tready;
    logic                s_axis_tuser;
    logic [Databits-1:0] m_axis_tdata;
    logic                m_axis_tvalid;
    logic                m_axis_tready;
    logic                m_axis_tuser;

    // Receiver / consumer side: produces s_axis beats, consumes m_axis beats.
    modport master (
        output s_axis_tdata,
        output s_axis_tvalid,
        input  s_axis_tready,
        output s_axis_tuser,
        input  m_axis_tdata,
        input  m_axis_tvalid,
        output m_axis_tready,
        input  m_axis_tuser
    );

    // FIFO side: accepts s_axis beats, presents m_axis beats.
    modport slave (
        input  s_axis_tdata,
        input  s_axis_tvalid,
        output s_axis_tready,
        input  s_axis_tuser,
        output m_axis_tdata,
        output m_axis_tvalid,
        input  m_axis_tready,
        output m_axis_tuser
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive-side elastic buffer behind the UART receiver.
// Show-ahead FIFO storing each character with its parity-error flag; the input
// side cannot be stalled, so beats arriving while full (and not popping) are
// dropped and flagged in a sticky overflow bit.
// Optional feature macro: UART_RX_FIFO_DROP_CNT_EN adds a saturating 16-bit
// drop_count output.
module uart_rx_fifo #(
    parameter int  Databits  = 8,
    parameter int  Depth     = 16,
    parameter int  AfThresh  = 12,
    localparam int AddrWidth = $clog2(Depth)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    uart_rx_fifo_if.slave        bus,
    output logic [AddrWidth:0]   count,
    output logic                 almost_full,
    output logic                 overflow,
    input  logic                 overflow_clr
`ifdef UART_RX_FIFO_DROP_CNT_EN
    ,
    output logic [15:0]          drop_count
`endif
);

    localparam logic [AddrWidth:0]   FullCount = (AddrWidth + 1)'(Depth);
    localparam logic [AddrWidth:0]   AfCount   = (AddrWidth + 1)'(AfThresh);
    localparam logic [AddrWidth:0]   CountOne  = (AddrWidth + 1)'(1);
    localparam logic [AddrWidth-1:0] PtrOne    = AddrWidth'(1);

    // Each entry holds {tuser, tdata}.
    logic [Databits:0]    mem [Depth];
    logic [AddrWidth-1:0] wr_ptr;
    logic [AddrWidth-1:0] rd_ptr;
    logic [AddrWidth:0]   count_next;
    logic                 not_empty;
    logic                 full;
    logic                 pop;
    logic                 push;
    logic                 drop;

    // The serial line cannot be paused, so the input is always ready.
    assign bus.s_axis_tready = 1'b1;

    assign not_empty = (count != '0);
    assign full      = (count == FullCount);

    // Head entry is presented straight from storage (first-word fall-through).
    assign bus.m_axis_tvalid = not_empty;
    assign bus.m_axis_tdata  = mem[rd_ptr][Databits-1:0];
    assign bus.m_axis_tuser  = mem[rd_ptr][Databits];

    // A pop in the same cycle frees a slot, so a full FIFO still accepts then.
    assign pop  = not_empty & bus.m_axis_tready;
    assign push = bus.s_axis_tvalid & (!full | pop);
    assign drop = bus.s_axis_tvalid & full & !pop;

    // Occupancy after this edge; also feeds the registered almost_full.
    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + CountOne;
        end else if (pop && !push) begin
            count_next = count - CountOne;
        end
    end

    // Storage write; reset clears contents so the head reads 0 when empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < Depth; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= {bus.s_axis_tuser, bus.s_axis_tdata};
        end
    end

    // Read/write pointers wrap naturally at Depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PtrOne;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PtrOne;
            end
        end
    end

    // Occupancy and almost_full both come from registers only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count       <= '0;
            almost_full <= 1'b0;
        end else begin
            count       <= count_next;
            almost_full <= (count_next >= AfCount);
        end
    end

    // Sticky overflow flag; a drop in the clearing cycle keeps it set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (overflow_clr) begin
            overflow <= 1'b0;
        end
    end

`ifdef UART_RX_FIFO_DROP_CNT_EN
    // Saturating drop counter; a drop during a clear restarts it at 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_count <= '0;
        end else if (drop) begin
            if (overflow_clr) begin
                drop_count <= 16'd1;
            end else if (drop_count != 16'hFFFF) begin
                drop_count <= drop_count + 16'd1;
            end
        end else if (overflow_clr) begin
            drop_count <= '0;
        end
    end
`else
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed scenarios plus random traffic, all checked
// every cycle against a queue-based model of the FIFO contents and flags.
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;
    localparam int AF    = 12;

    logic       clk;
    logic       rst_n;
    logic [4:0] count;
    logic       almost_full;
    logic       overflow;
    logic       overflow_clr;
`ifdef UART_RX_FIFO_DROP_CNT_EN
    logic [15:0] drop_count;
`endif

    uart_rx_fifo_if #(.Databits(8)) bus ();

    uart_rx_fifo #(
        .Databits (8),
        .Depth    (DEPTH),
        .AfThresh (AF)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .count        (count),
        .almost_full  (almost_full),
        .overflow     (overflow),
        .overflow_clr (overflow_clr)
`ifdef UART_RX_FIFO_DROP_CNT_EN
        ,
        .drop_count   (drop_count)
`endif
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    logic [8:0] exp_q[$];     // {tuser, tdata}
    logic       exp_ovf;
    int         exp_drops;
    int         total;
    int         bad;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Compare every visible output against the model.
    task automatic check_outputs();
        check("tready", 32'(bus.s_axis_tready), 32'd1);
        check("tvalid", 32'(bus.m_axis_tvalid), 32'(exp_q.size() != 0));
        check("count", 32'(count), 32'(exp_q.size()));
        check("almost_full", 32'(almost_full), 32'(exp_q.size() >= AF));
        check("overflow", 32'(overflow), 32'(exp_ovf));
        if (exp_q.size() != 0) begin
            check("tdata", 32'(bus.m_axis_tdata), 32'(exp_q[0][7:0]));
            check("tuser", 32'(bus.m_axis_tuser), 32'(exp_q[0][8]));
        end
`ifdef UART_RX_FIFO_DROP_CNT_EN
        check("drop_count", 32'(drop_count), 32'(exp_drops));
`endif
    endtask

    // ---------------- driver tasks ----------------
    // One clock cycle: drive inputs, check at the falling edge, advance the model.
    task automatic cycle(input logic v, input logic [7:0] d, input logic u,
                         input logic rdy, input logic clr);
        bit do_pop;
        bit do_push;
        bit do_drop;
        bus.s_axis_tvalid = v;
        bus.s_axis_tdata  = d;
        bus.s_axis_tuser  = u;
        bus.m_axis_tready = rdy;
        overflow_clr      = clr;
        @(negedge clk);
        check_outputs();
        do_pop  = (exp_q.size() != 0) && rdy;
        do_push = v && ((exp_q.size() < DEPTH) || do_pop);
        do_drop = v && !do_push;
        if (do_pop) void'(exp_q.pop_front());
        if (do_push) exp_q.push_back({u, d});
        if (do_drop) exp_ovf = 1'b1;
        else if (clr) exp_ovf = 1'b0;
        if (do_drop) exp_drops = clr ? 1 : ((exp_drops < 65535) ? exp_drops + 1 : 65535);
        else if (clr) exp_drops = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    endtask

    // Asynchronous reset, checked immediately without waiting for a clock edge.
    task automatic do_reset();
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tdata  = 8'h00;
        bus.s_axis_tuser  = 1'b0;
        bus.m_axis_tready = 1'b0;
        overflow_clr      = 1'b0;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        exp_ovf   = 1'b0;
        exp_drops = 0;
        check("rst_tvalid", 32'(bus.m_axis_tvalid), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_tdata", 32'(bus.m_axis_tdata), 32'd0);
        check("rst_tuser", 32'(bus.m_axis_tuser), 32'd0);
        check("rst_af", 32'(almost_full), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_tready", 32'(bus.s_axis_tready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        total     = 0;
        bad       = 0;
        exp_ovf   = 1'b0;
        exp_drops = 0;
        rst_n     = 1'b1;
        #3;
        do_reset();

        // Single beat, one-cycle latency, then pop.
        cycle(1'b1, 8'h41, 1'b0, 1'b0, 1'b0);
        check("one_tvalid", 32'(bus.m_axis_tvalid), 32'd1);
        idle(1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        idle(1);

        // Fill to full, overflow on the 17th byte, drain in order.
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
        check("full_count", 32'(count), 32'd16);
        check("full_ovf", 32'(overflow), 32'd1);
        drain(DEPTH + 1);

        // Full with simultaneous pop: the new beat is accepted and read last.
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(8'h80 + i), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'h55, 1'b0, 1'b1, 1'b0);
        check("pp_count", 32'(count), 32'd16);
        check("pp_no_ovf", 32'(overflow), 32'd0);
        drain(DEPTH + 1);

        // Parity flag travels with its character.
        cycle(1'b1, 8'h3C, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 8'h3D, 1'b0, 1'b0, 1'b0);
        drain(3);

        // Empty with valid and ready together: written, not bypassed.
        cycle(1'b1, 8'h99, 1'b1, 1'b1, 1'b0);
        drain(2);

        // Wrap: push/pop traffic with random ready.
        for (int i = 0; i < 40; i++)
            cycle(1'b1, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'b0);
        drain(DEPTH + 2);

        // Random traffic with occasional clears, biased towards overflow.
        for (int i = 0; i < 400; i++)
            cycle(1'($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
                  1'($urandom_range(0, 15) == 0));
        drain(DEPTH + 2);

        // Drop and clear in the same cycle: overflow stays set.
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'hAA, 1'b0, 1'b0, 1'b1);
        check("drop_clr_ovf", 32'(overflow), 32'd1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // Reset mid-burst, then confirm old contents do not reappear.
        drain(4);
        cycle(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
        bus.s_axis_tvalid = 1'b1;
        bus.s_axis_tdata  = 8'h12;
        #2;
        do_reset();
        cycle(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
        drain(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
